// File: rtl/palette_scanout.sv
// Display fetch stage: reads two-pixel words over Avalon-MM into a FIFO and
// streams RGB565 pixels in raster order, with start-of-frame and end-of-line marks.
module palette_scanout #(
  parameter int WIDTH           = 480,
  parameter int HEIGHT          = 272,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              frame_done,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
);

  localparam int WORDS  = WIDTH * HEIGHT / 2;
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
  localparam int X_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issuedCnt_q, issuedCnt_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [FCNT_W-1:0] fifoCount_q, fifoCount_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic              half_q, half_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              done_q, done_d;
  logic [31:0]       fifoMem_q [FIFO_DEPTH];

  logic [SUM_W-1:0] inFlight;
  logic             canIssue;
  logic             readReq;
  logic             accept;
  logic             push;
  logic             pop;
  logic             pixValid;
  logic             handshake;
  logic             lastPixel;
  logic             xAtEnd;
  logic [31:0]      fifoHead;

  // Words already buffered plus words still owed must fit in the FIFO, so a
  // response always finds a free slot.
  assign inFlight  = SUM_W'(fifoCount_q) + SUM_W'(outstanding_q);
  assign canIssue  = (inFlight < SUM_W'(FIFO_DEPTH)) &&
                     (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign readReq   = (state_q == FETCH) && canIssue;
  assign accept    = readReq && !avm_waitrequest;
  assign push      = avm_readdatavalid && (outstanding_q != '0);
  assign pixValid  = (fifoCount_q != '0);
  assign handshake = pixValid && pix_ready;
  assign pop       = handshake && half_q;
  assign xAtEnd    = (x_q == X_W'(WIDTH - 1));
  assign lastPixel = handshake && xAtEnd && (y_q == Y_W'(HEIGHT - 1));
  assign fifoHead  = fifoMem_q[rdPtr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = FETCH;
      FETCH:   if (accept && (issuedCnt_q == CNT_W'(WORDS - 1))) state_d = DRAIN;
      DRAIN:   if (lastPixel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d        = addr_q;
    issuedCnt_d   = issuedCnt_q;
    outstanding_d = outstanding_q;
    fifoCount_d   = fifoCount_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    half_d        = half_q ^ handshake;
    x_d           = x_q;
    y_d           = y_q;
    done_d        = (state_q == DRAIN) && lastPixel;

    if ((state_q == IDLE) && frame_start) begin
      addr_d      = frame_base;
      issuedCnt_d = '0;
    end else if (accept) begin
      addr_d      = addr_q + ADDR_W'(1);
      issuedCnt_d = issuedCnt_q + CNT_W'(1);
    end

    if (accept && !push) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!accept && push) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    if (push && !pop) begin
      fifoCount_d = fifoCount_q + FCNT_W'(1);
    end else if (!push && pop) begin
      fifoCount_d = fifoCount_q - FCNT_W'(1);
    end

    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);

    // Raster position tracks the pixel currently presented on the output.
    if (handshake) begin
      if (xAtEnd) begin
        x_d = '0;
        y_d = (y_q == Y_W'(HEIGHT - 1)) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      issuedCnt_q   <= '0;
      outstanding_q <= '0;
      fifoCount_q   <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      half_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      done_q        <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      issuedCnt_q   <= issuedCnt_d;
      outstanding_q <= outstanding_d;
      fifoCount_q   <= fifoCount_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      half_q        <= half_d;
      x_q           <= x_d;
      y_q           <= y_d;
      done_q        <= done_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= avm_readdata;
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign avm_read    = readReq;
  assign avm_address = addr_q;
  assign pix_valid   = pixValid;
  assign pix_data    = pixValid ? (half_q ? fifoHead[15:0] : fifoHead[31:16]) : 16'h0000;
  assign pix_sof     = pixValid && (x_q == '0) && (y_q == '0);
  assign pix_eol     = pixValid && xAtEnd;

endmodule

// File: tb/tb_palette_scanout.sv
// Directed bench for palette_scanout: latency-2 responder, optional stalls,
// backpressure, ignored restart, address wrap and mid-frame reset.
module tb_palette_scanout;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int DEPTH  = 4;
  localparam int MAXOUT = 2;
  localparam int AW     = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          busy, frame_done, avm_read;
  logic [AW-1:0] avm_address;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [15:0]   pix_data;
  logic          pix_valid, pix_sof, pix_eol;
  logic          pix_ready = 1'b1;

  palette_scanout #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXOUT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_base(frame_base),
    .busy(busy), .frame_done(frame_done), .avm_read(avm_read), .avm_address(avm_address),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;

  int            cyc = 0;
  rsp_t          rspQ[$];
  logic [AW-1:0] stallAddr = '1;
  int            stallLeft = 0;

  logic [AW-1:0] accQ[$];
  logic [15:0]   pixQ[$];
  bit            sofQ[$];
  bit            eolQ[$];
  int            doneCount = 0, doneCyc = 0, lastHsCyc = 0, stallSeen = 0, maxOut = 0;
  bit            busyAtDone = 0, busyAtLastHs = 0;
  int            tbOut = 0, tbFifo = 0;
  bit            tbHalf = 0, ruleViol = 0, overflow = 0, stableViol = 0;
  bit            holdPrev = 0, prevSof = 0, prevEol = 0;
  logic [15:0]   prevData = '0;

  // Responder: answers each accepted read two cycles later, stalls on request.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
        logic [15:0] a16;
        a16 = rspQ[0].addr[15:0];
        avm_readdatavalid = 1'b1;
        avm_readdata      = {a16, ~a16};
        void'(rspQ.pop_front());
      end
      avm_waitrequest = 1'b0;
      if (avm_read && avm_address == stallAddr && stallLeft > 0) begin
        avm_waitrequest = 1'b1;
        stallLeft--;
      end
    end
  end

  // Monitor at the falling edge: logs transfers and models occupancy.
  initial begin
    forever begin
      @(negedge clk);
      if (avm_read && !avm_waitrequest) rspQ.push_back('{avm_address, cyc + 2});
      if (reset) begin
        tbOut = 0; tbFifo = 0; tbHalf = 0; holdPrev = 0;
      end else begin
        bit pushNow;
        if (avm_read && ((tbFifo + tbOut >= DEPTH) || (tbOut >= MAXOUT))) ruleViol = 1;
        if (avm_read && avm_address == stallAddr) stallSeen++;
        if (holdPrev && (!pix_valid || pix_data !== prevData || pix_sof !== prevSof ||
                         pix_eol !== prevEol)) stableViol = 1;
        holdPrev = pix_valid && !pix_ready;
        prevData = pix_data; prevSof = pix_sof; prevEol = pix_eol;
        if (frame_done) begin
          doneCount++; doneCyc = cyc; busyAtDone = busy;
        end
        pushNow = avm_readdatavalid && (tbOut > 0);
        if (pix_valid && pix_ready) begin
          pixQ.push_back(pix_data); sofQ.push_back(pix_sof); eolQ.push_back(pix_eol);
          lastHsCyc = cyc; busyAtLastHs = busy;
          if (tbHalf) tbFifo--;
          tbHalf = !tbHalf;
        end
        if (avm_read && !avm_waitrequest) begin
          accQ.push_back(avm_address);
          tbOut++;
        end
        if (pushNow) begin
          tbOut--; tbFifo++;
        end
        if (tbOut > maxOut) maxOut = tbOut;
        if (tbFifo > DEPTH) overflow = 1;
      end
    end
  end

  task automatic clearLogs();
    accQ.delete(); pixQ.delete(); sofQ.delete(); eolQ.delete();
    doneCount = 0; stallSeen = 0; maxOut = 0;
    ruleViol = 0; overflow = 0; stableViol = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Pulses frame_start; returns one cycle after it was sampled.
  task automatic applyStimulus(input logic [AW-1:0] base);
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_base  = base;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (doneCount == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (doneCount == 0) checkOutput($sformatf("%s timeout", tag), 32'd0, 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput($sformatf("%s busy", tag), busy, 0);
    checkOutput($sformatf("%s frame_done", tag), frame_done, 0);
    checkOutput($sformatf("%s avm_read", tag), avm_read, 0);
    checkOutput($sformatf("%s avm_address", tag), avm_address, 0);
    checkOutput($sformatf("%s pix_valid", tag), pix_valid, 0);
    checkOutput($sformatf("%s pix_data", tag), pix_data, 0);
    checkOutput($sformatf("%s pix_sof", tag), pix_sof, 0);
    checkOutput($sformatf("%s pix_eol", tag), pix_eol, 0);
  endtask

  task automatic checkFrame(input string tag, input logic [AW-1:0] base);
    logic [7:0] sofV, eolV;
    checkOutput($sformatf("%s reads", tag), accQ.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] expA;
      expA = base + AW'(i);
      checkOutput($sformatf("%s addr%0d", tag, i), accQ[i], expA);
    end
    checkOutput($sformatf("%s pixels", tag), pixQ.size(), 8);
    sofV = '0;
    eolV = '0;
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] wa;
      logic [15:0]   lo16, expP;
      wa   = base + AW'(i / 2);
      lo16 = wa[15:0];
      expP = (i % 2 == 0) ? lo16 : ~lo16;
      checkOutput($sformatf("%s pix%0d", tag, i), pixQ[i], expP);
    end
    for (int i = 0; i < pixQ.size() && i < 8; i++) begin
      sofV[i] = sofQ[i];
      eolV[i] = eolQ[i];
    end
    checkOutput($sformatf("%s sof", tag), sofV, 8'b0000_0001);
    checkOutput($sformatf("%s eol", tag), eolV, 8'b1000_1000);
    checkOutput($sformatf("%s doneCount", tag), doneCount, 1);
    checkOutput($sformatf("%s doneLatency", tag), doneCyc - lastHsCyc, 1);
    checkOutput($sformatf("%s busyAtDone", tag), busyAtDone, 0);
    checkOutput($sformatf("%s busyAtLastPix", tag), busyAtLastHs, 1);
    checkOutput($sformatf("%s issueRule", tag), ruleViol, 0);
    checkOutput($sformatf("%s fifoOverflow", tag), overflow, 0);
    checkOutput($sformatf("%s holdStable", tag), stableViol, 0);
    checkOutput($sformatf("%s idleAfter", tag), busy, 0);
  endtask

  initial begin
    int acc101;
    int n;

    // Reset state
    waitCycles(2);
    checkIdleOutputs("reset");
    reset = 1'b0;

    // 1: basic frame and start latency
    clearLogs();
    applyStimulus(24'h000100);
    checkOutput("t1 latencyRead", avm_read, 1);
    checkOutput("t1 latencyAddr", avm_address, 24'h000100);
    checkOutput("t1 busy", busy, 1);
    waitDone("t1");
    waitCycles(5);
    checkFrame("t1", 24'h000100);

    // 2: waitrequest held for three cycles on 0x101
    clearLogs();
    stallAddr = 24'h000101;
    stallLeft = 3;
    applyStimulus(24'h000100);
    waitDone("t2");
    waitCycles(5);
    acc101 = 0;
    foreach (accQ[i]) if (accQ[i] == 24'h000101) acc101++;
    checkOutput("t2 heldCycles", stallSeen, 4);
    checkOutput("t2 accept101", acc101, 1);
    checkFrame("t2", 24'h000100);
    stallAddr = '1;
    stallLeft = 0;

    // 3: full backpressure, then release
    clearLogs();
    pix_ready = 1'b0;
    applyStimulus(24'h000100);
    waitCycles(20);
    checkOutput("t3 readsStalled", accQ.size(), 4);
    checkOutput("t3 avm_read", avm_read, 0);
    checkOutput("t3 maxOutstanding", maxOut, 2);
    checkOutput("t3 pix_valid", pix_valid, 1);
    checkOutput("t3 pix_data", pix_data, 16'h0100);
    checkOutput("t3 pix_sof", pix_sof, 1);
    checkOutput("t3 pix_eol", pix_eol, 0);
    checkOutput("t3 busyHeld", busy, 1);
    checkOutput("t3 noDone", doneCount, 0);
    pix_ready = 1'b1;
    waitDone("t3");
    waitCycles(5);
    checkFrame("t3", 24'h000100);

    // 4: second frame_start during FETCH is ignored
    clearLogs();
    applyStimulus(24'h000100);
    frame_start = 1'b1;
    frame_base  = 24'h000200;
    @(posedge clk); #1;
    frame_start = 1'b0;
    waitDone("t4");
    waitCycles(8);
    checkFrame("t4", 24'h000100);

    // 5: address wrap
    clearLogs();
    applyStimulus(24'hFFFFFE);
    waitDone("t5");
    waitCycles(5);
    checkFrame("t5", 24'hFFFFFE);

    // 6: reset after two reads are accepted; late responses must be ignored
    clearLogs();
    applyStimulus(24'h000100);
    n = 0;
    while (accQ.size() < 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t6 twoReads", accQ.size(), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkIdleOutputs("t6 afterReset");
    waitCycles(8);
    checkOutput("t6 noPixels", pixQ.size(), 0);
    checkOutput("t6 busyLow", busy, 0);
    checkOutput("t6 noValid", pix_valid, 0);
    checkOutput("t6 noDone", doneCount, 0);
    clearLogs();
    applyStimulus(24'h000100);
    waitDone("t6");
    waitCycles(5);
    checkFrame("t6", 24'h000100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/palette_scanout.md
Name: palette_scanout

Overview:
- Display-side fetch stage that reads palette-expanded pixels for one frame and streams them, in raster order, to the LCD timing/output stage.
- Acts as an Avalon-MM read master on the palette block's slave port. Each 32-bit word returned carries two RGB565 pixels.
- Buffers the words in a FIFO and keeps the number of reads in flight below the free FIFO space, so returned data is never dropped.

Parameters:
- WIDTH, 480, pixels per line; must be even.
- HEIGHT, 272, lines per frame.
- FIFO_DEPTH, 64, 32-bit word entries; power of two, at least 4.
- MAX_OUTSTANDING, 8, maximum reads accepted but not yet answered.
- ADDR_W, 24, width of the master address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle request to fetch a frame
- frame_base  in  ADDR_W  word address of the frame's first word; sampled when frame_start is accepted
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse after the last pixel handshake
- avm_read  out  1  read request
- avm_address  out  ADDR_W  word address of the read
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  two pixels per word
- avm_readdatavalid  in  1  response strobe
- pix_data  out  16  RGB565 pixel
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  downstream accepts the pixel
- pix_sof  out  1  marks the first pixel of the frame
- pix_eol  out  1  marks the last pixel of each line

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high.
- Reset values: every output is 0, the FIFO is empty, all counters are 0, and the FSM is in IDLE.
- Words per frame: W = WIDTH*HEIGHT/2. Reads are issued to frame_base, frame_base+1, ... frame_base+W-1. The address wraps modulo 2^ADDR_W.
- FSM states:
  - IDLE: frame_start=1 latches frame_base, sets busy, and moves to FETCH.
  - FETCH: issues reads. After the W-th read is accepted, moves to DRAIN.
  - DRAIN: waits until all responses have arrived and the last pixel has been handshaked. It then pulses frame_done for one cycle, clears busy in that same cycle, and returns to IDLE.
- frame_start outside IDLE is ignored.
- Latency: frame_start sampled in cycle N gives avm_read=1 with avm_address=frame_base in cycle N+1.
- Read issue rule: avm_read may rise only when both of these hold:
  - fifo_count + outstanding < FIFO_DEPTH
  - outstanding < MAX_OUTSTANDING
- A read is accepted when avm_read=1 and avm_waitrequest=0.
- While avm_waitrequest=1, avm_read and avm_address stay stable, and the address does not advance.
- Outstanding counter: increments on acceptance and decrements on avm_readdatavalid. A simultaneous acceptance and response leaves it unchanged.
- avm_readdatavalid while outstanding==0 (stray response) is ignored: no FIFO write, and the counter does not go below 0.
- FIFO write: on avm_readdatavalid the word is written into the FIFO. It is visible at the output no earlier than the next cycle.
- FIFO read and pixel order: pix_valid=1 whenever the FIFO is non-empty.
  - The first pixel is word[31:16]; the second is word[15:0].
  - A half-select bit toggles on each handshake (pix_valid && pix_ready).
  - The FIFO pops on the handshake of the second half.
- pix_data, pix_sof and pix_eol stay stable while pix_valid=1 and pix_ready=0.
- Position counters x and y advance on each handshake. x wraps at WIDTH-1 and y increments on that wrap.
  - pix_sof = pix_valid && x==0 && y==0.
  - pix_eol = pix_valid && x==WIDTH-1.
- Simultaneous FIFO push and pop are allowed; fifo_count is unchanged. Overflow cannot occur under the issue rule; an assertion in the bench checks this.
- Reset mid-frame: all state clears on the next edge, avm_read drops, and responses from reads issued before reset are ignored as stray responses.

Test Plan:
1. Basic frame (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4, MAX_OUTSTANDING=2). Responder: latency 2, no stalls, readdata = {addr[15:0], ~addr[15:0]}. frame_base=0x000100, pix_ready=1.
   - Required: reads to 0x100..0x103.
   - Required: 8 pixels in the order 0x0100, 0xFEFF, 0x0101, 0xFEFE, and so on.
   - Required: sof on pixel 0, eol on pixels 3 and 7.
   - Required: frame_done pulses once, one cycle after the last handshake, and busy falls in the same cycle.
2. Waitrequest: avm_waitrequest held high for 3 cycles on the read to 0x101.
   - Required: avm_read=1 and avm_address=0x101 held for all 4 cycles, exactly one acceptance, and no duplicate pixels.
3. Backpressure: pix_ready=0 for the whole frame.
   - Required: issuing stops when fifo_count + outstanding = 4, outstanding never exceeds 2, and pix_data holds 0x0100 with sof=1.
   - Then release pix_ready: the remaining reads complete and the pixel order is unchanged.
4. frame_start pulsed again during FETCH with frame_base=0x200.
   - Required: ignored; addresses stay in 0x100..0x103 and exactly one frame_done is produced.
5. Address wrap: frame_base=0xFFFFFE.
   - Required: reads to 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
6. Reset mid-frame: reset for 1 cycle after 2 reads are issued, and the responder still returns both responses.
   - Required: all outputs are 0 the next cycle, no pixel is output, and busy=0.
   - Required: a new frame_start then gives a correct full frame.
